// File: rtl/maquina_cafe_teorica.sv
// Coin-operated beverage controller: credit, drink selection,
// ingredient valve sequencing and a two-digit credit display.
module maquina_cafe_teorica #(
    parameter int STEP_CYCLES  = 2,
    parameter int READY_CYCLES = 2
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       e,
    input  logic       l,
    input  logic       x,
    input  logic       m,
    input  logic       a,
    input  logic       C,
    input  logic       Q,
    output logic       bebidaLista,
    output logic       agua,
    output logic       cafe,
    output logic       leche,
    output logic       choco,
    output logic       azucar,
    output logic [6:0] hex1,
    output logic [6:0] hex2
);

    typedef enum logic [2:0] {
        S_IDLE, S_AGUA, S_CAFE, S_LECHE, S_CHOCO, S_AZUCAR, S_READY
    } state_t;

    localparam logic [1:0] D_ESP = 2'd0;
    localparam logic [1:0] D_LEC = 2'd1;
    localparam logic [1:0] D_CHO = 2'd2;
    localparam logic [1:0] D_MOC = 2'd3;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] credit_q, credit_d;
    logic [1:0] drink_q, drink_d;
    logic       sugar_q, sugar_d;
    logic [5:0] prev_q;
    logic [5:0] ev;

    logic       sel;
    logic [3:0] price;
    logic [1:0] sel_drink;
    logic [4:0] add;
    logic [3:0] base;
    logic [4:0] sum;
    logic       need_cafe, need_leche, need_choco;

    // Order {C,Q,e,l,x,m}; an event is a raw input high over a low history.
    assign ev = {C, Q, e, l, x, m} & ~prev_q;

    assign need_cafe  = (drink_q != D_CHO);
    assign need_leche = (drink_q != D_ESP);
    assign need_choco = (drink_q == D_CHO) || (drink_q == D_MOC);

    function automatic state_t next_step(
        input state_t s, input logic nc, input logic nl,
        input logic nx, input logic na
    );
        state_t n;
        n = S_READY;
        if (s == S_AGUA && nc)
            n = S_CAFE;
        else if ((s == S_AGUA || s == S_CAFE) && nl)
            n = S_LECHE;
        else if ((s == S_AGUA || s == S_CAFE || s == S_LECHE) && nx)
            n = S_CHOCO;
        else if (s != S_AZUCAR && na)
            n = S_AZUCAR;
        return n;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] r;
        r = 7'b1111111;
        case (d)
            4'd0: r = 7'b1000000;
            4'd1: r = 7'b1111001;
            4'd2: r = 7'b0100100;
            4'd3: r = 7'b0110000;
            4'd4: r = 7'b0011001;
            4'd5: r = 7'b0010010;
            4'd6: r = 7'b0000010;
            4'd7: r = 7'b1111000;
            4'd8: r = 7'b0000000;
            4'd9: r = 7'b0010000;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            credit_q <= '0;
            drink_q  <= D_ESP;
            sugar_q  <= 1'b0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            drink_q  <= drink_d;
            sugar_q  <= sugar_d;
            prev_q   <= {C, Q, e, l, x, m};
        end
    end

    always_comb begin
        sel       = 1'b1;
        price     = 4'd0;
        sel_drink = D_ESP;
        priority case (1'b1)
            ev[3]:   begin price = 4'd3; sel_drink = D_ESP; end
            ev[2]:   begin price = 4'd5; sel_drink = D_LEC; end
            ev[1]:   begin price = 4'd4; sel_drink = D_CHO; end
            ev[0]:   begin price = 4'd6; sel_drink = D_MOC; end
            default: sel = 1'b0;
        endcase
    end

    // Selection is judged on the old credit; a same-cycle coin still lands.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        credit_d = credit_q;
        drink_d  = drink_q;
        sugar_d  = sugar_q;
        add      = (ev[5] ? 5'd1 : 5'd0) + (ev[4] ? 5'd5 : 5'd0);
        base     = credit_q;
        sum      = '0;
        case (state_q)
            S_IDLE: begin
                if (sel && credit_q >= price) begin
                    base    = credit_q - price;
                    drink_d = sel_drink;
                    sugar_d = a;
                    cnt_d   = '0;
                    state_d = S_AGUA;
                end
                sum      = {1'b0, base} + add;
                credit_d = (sum <= 5'd15) ? sum[3:0] : base;
            end
            S_READY: begin
                if (cnt_q == 8'(READY_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                if (cnt_q == 8'(STEP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = next_step(state_q, need_cafe,
                                        need_leche, need_choco, sugar_q);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        agua        = (state_q == S_AGUA);
        cafe        = (state_q == S_CAFE);
        leche       = (state_q == S_LECHE);
        choco       = (state_q == S_CHOCO);
        azucar      = (state_q == S_AZUCAR);
        bebidaLista = (state_q == S_READY);
        hex2        = seg((credit_q >= 4'd10) ? 4'd1 : 4'd0);
        hex1        = seg((credit_q >= 4'd10) ? credit_q - 4'd10 : credit_q);
    end

endmodule

// File: tb/tb_maquina_cafe_teorica.sv
// Directed bench for maquina_cafe_teorica: coins, drinks, sugar,
// credit saturation, display digits and mid-dispense reset.
module tb_maquina_cafe_teorica;

    logic       clk_50Mhz = 1'b0;
    logic       rst;
    logic       e, l, x, m, a, C, Q;
    logic       bebidaLista, agua, cafe, leche, choco, azucar;
    logic [6:0] hex1, hex2;
    logic [5:0] outs;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D9 = 7'b0010000;

    maquina_cafe_teorica dut (
        .clk_50Mhz  (clk_50Mhz),
        .rst        (rst),
        .e          (e),
        .l          (l),
        .x          (x),
        .m          (m),
        .a          (a),
        .C          (C),
        .Q          (Q),
        .bebidaLista(bebidaLista),
        .agua       (agua),
        .cafe       (cafe),
        .leche      (leche),
        .choco      (choco),
        .azucar     (azucar),
        .hex1       (hex1),
        .hex2       (hex2)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    assign outs = {agua, cafe, leche, choco, azucar, bebidaLista};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic coin_c();
        C = 1'b1; tick(); C = 1'b0; tick();
    endtask

    task automatic coin_q();
        Q = 1'b1; tick(); Q = 1'b0; tick();
    endtask

    // mask {agua,cafe,leche,choco,azucar}: 2 cycles per step, 2 ready, idle
    task automatic check_seq(input string tag, input logic [4:0] mask);
        logic [5:0] ex;
        for (int i = 4; i >= 0; i--) begin
            if (mask[i]) begin
                ex = 6'd1 << (i + 1);
                for (int c = 0; c < 2; c++) begin
                    check(tag, 32'(outs), 32'(ex));
                    tick();
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            check({tag, "_rdy"}, 32'(outs), 32'(6'b000001));
            tick();
        end
        check({tag, "_idle"}, 32'(outs), 32'(6'b000000));
    endtask

    initial begin
        rst = 1'b1;
        {e, l, x, m, a, C, Q} = '0;
        tick();
        tick();
        check("rst_outs", 32'(outs), 32'(0));
        check("rst_hex1", 32'(hex1), 32'(D0));
        check("rst_hex2", 32'(hex2), 32'(D0));
        rst = 1'b0;
        tick();
        check("rel_hex1", 32'(hex1), 32'(D0));

        C = 1'b1; tick(); C = 1'b0;
        check("c1_hex1", 32'(hex1), 32'(D1));
        Q = 1'b1; repeat (3) tick(); Q = 1'b0;
        check("q6_hex1", 32'(hex1), 32'(D6));
        C = 1'b1; repeat (3) tick(); C = 1'b0;
        check("c7_hex1", 32'(hex1), 32'(D7));
        check("c7_hex2", 32'(hex2), 32'(D0));

        l = 1'b1; tick();
        check("lec_hex1", 32'(hex1), 32'(D2));
        check_seq("lec", 5'b11100);
        tick();
        check("lec_hold", 32'(outs), 32'(0));
        l = 1'b0; tick();

        e = 1'b1; tick();
        check("esp_nocred_hex1", 32'(hex1), 32'(D2));
        check("esp_nocred_outs", 32'(outs), 32'(0));
        tick();
        check("esp_nocred_outs2", 32'(outs), 32'(0));
        e = 1'b0; tick();

        coin_q(); coin_c(); coin_c();
        check("c9_hex1", 32'(hex1), 32'(D9));
        m = 1'b1; a = 1'b1; tick(); m = 1'b0; a = 1'b0;
        check("moc_hex1", 32'(hex1), 32'(D3));
        C = 1'b1; Q = 1'b1;
        check_seq("moc", 5'b11111);
        C = 1'b0; Q = 1'b0; tick();
        check("moc_coins_ign", 32'(hex1), 32'(D3));

        coin_q(); coin_q(); coin_c();
        check("c14_hex1", 32'(hex1), 32'(D4));
        coin_q();
        check("sat_hex2", 32'(hex2), 32'(D1));
        check("sat_hex1", 32'(hex1), 32'(D4));
        coin_c();
        check("c15_hex1", 32'(hex1), 32'(D5));

        x = 1'b1; tick(); x = 1'b0;
        check("cho_hex1", 32'(hex1), 32'(D1));
        check("cho_agua", 32'(outs), 32'(6'b100000));
        tick(); tick();
        check("cho_leche", 32'(outs), 32'(6'b001000));
        rst = 1'b1; #1;
        check("mid_rst_outs", 32'(outs), 32'(0));
        check("mid_rst_hex1", 32'(hex1), 32'(D0));
        check("mid_rst_hex2", 32'(hex2), 32'(D0));
        tick(); rst = 1'b0; tick();

        C = 1'b1; Q = 1'b1; tick(); C = 1'b0; Q = 1'b0;
        check("cq6_hex1", 32'(hex1), 32'(D6));
        tick();
        x = 1'b1; C = 1'b1; tick(); x = 1'b0; C = 1'b0;
        check("selcoin_hex1", 32'(hex1), 32'(D3));
        check_seq("cho", 5'b10110);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/maquina_cafe_teorica.md
Name: maquina_cafe_teorica

Overview:
- Coin-operated beverage vending controller.
- Accepts 100 and 500 coins into a credit register and shows the credit on two 7-segment digits.
- Accepts one of four drink selections with an optional sugar request, deducts the price, then sequences ingredient valves and asserts a drink-ready flag.
- Top-level FSM of the coffee-machine lab, driven by the 50 MHz board clock; buttons and coins arrive pre-debounced.

Parameters:
- STEP_CYCLES, default 2: clock cycles each ingredient output stays high.
- READY_CYCLES, default 2: clock cycles bebidaLista stays high.

Ports:
- clk_50Mhz  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- e  in  1  select espresso, price 300.
- l  in  1  select coffee with milk, price 500.
- x  in  1  select chocolate, price 400.
- m  in  1  select mocaccino, price 600.
- a  in  1  sugar request, sampled together with the selection.
- C  in  1  coin 100 (level; one coin per rising edge).
- Q  in  1  coin 500 (level; one coin per rising edge).
- bebidaLista  out  1  drink finished.
- agua  out  1  water valve.
- cafe  out  1  coffee valve.
- leche  out  1  milk valve.
- choco  out  1  chocolate valve.
- azucar  out  1  sugar valve.
- hex1  out  7  units digit of credit/100; active-low, bit order {g,f,e,d,c,b,a}.
- hex2  out  7  tens digit of credit/100; same encoding.

Behaviour:
- Reset (async, rst=1):
  - credit = 0; FSM in IDLE; all valve outputs and bebidaLista = 0.
  - Edge-detect registers cleared to 0.
  - hex1 = hex2 = 7'b1000000 ("0").
- Edge detection:
  - C, Q, e, l, x and m are each registered every cycle.
  - An event is in_now=1 while in_prev=0.
  - An input already high when reset releases generates an event on the first clock after release (prev cleared to 0).
- Credit:
  - 4-bit register in units of 100; range 0..15.
  - In IDLE: a C event adds 1 and a Q event adds 5, visible on the next rising edge.
  - Simultaneous C and Q events add 6.
  - An add that would exceed 15 is discarded entirely; credit is unchanged.
  - Coins outside IDLE are ignored (not queued).
- Selection (IDLE only):
  - Priority e > l > x > m when several selection events coincide.
  - Price units: e=3, l=5, x=4, m=6.
  - If credit >= price: subtract price, latch the drink and sugar=a, and go to the first step on the next edge.
  - If credit < price: ignore the selection; stay in IDLE with credit unchanged.
  - A coin event and a selection event in the same cycle: the selection is evaluated against the old credit and the coin is still added. Net credit = old - price + coin.
- Ingredient sequence, steps in fixed order AGUA, CAFE, LECHE, CHOCO, AZUCAR:
  - Only steps the drink needs are visited; each lasts STEP_CYCLES cycles.
  - Exactly one valve output is high, registered, during its step.
  - Espresso: AGUA, CAFE.
  - Coffee with milk: AGUA, CAFE, LECHE.
  - Chocolate: AGUA, LECHE, CHOCO.
  - Mocaccino: AGUA, CAFE, LECHE, CHOCO.
  - AZUCAR is appended only if sugar was latched.
- READY state: bebidaLista=1 for READY_CYCLES cycles, then return to IDLE.
  - A selection held high across the whole sequence does not retrigger; only a new rising edge does.
- Display:
  - Combinational from credit: hex2 = credit/10 (0 or 1), hex1 = credit%10.
  - Standard active-low digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - The display shows the current credit in every state.
- Reset mid-sequence: outputs drop immediately; the drink and its credit are lost.

Test Plan:
- Reset with all inputs low, then release → credit 0, hex2 = hex1 = 1000000, all outputs 0.
- Coin sequence C (1 cycle), Q (3 cycles), C (3 cycles) → credit 1, then 6, then 7 (not 1+15); hex1 = 1111000 after the last coin.
- Credit 7, pulse l with a=0 → credit 2 (hex1 = 0100100).
  - Valves then run agua, cafe, leche, 2 cycles each.
  - bebidaLista then high for 2 cycles; azucar never high; FSM back in IDLE.
- Credit 2, press e → ignored, no valve activity, credit stays 2.
- Credit 9, press m with a=1 → credit 3.
  - Sequence agua, cafe, leche, choco, azucar, then bebidaLista.
  - Coins inserted during the sequence leave credit at 3.
- Credit 14, insert Q → credit stays 14 (hex2 = 1111001, hex1 = 0011001).
  - Then insert C → credit 15, hex1 = 0010010.
  - Assert rst during a later dispense → all outputs 0 and credit 0 immediately.
